// File: rtl/ram_stream_reader_if.sv
//------------------------------------------------------------------------------
// ram_stream_reader_if : command, RAM read-port and stream bundle
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface ram_stream_reader_if #(
  parameter int WIDTHB     = 9,
  parameter int ADDRWIDTHB = 12,
  parameter int LENWIDTH   = 13
);
  logic                  start;
  logic [ADDRWIDTHB-1:0] base_addr;
  logic [LENWIDTH-1:0]   length;
  logic                  busy;
  logic                  done;
  logic                  reB;
  logic [ADDRWIDTHB-1:0] addrB;
  logic [WIDTHB-1:0]     doB;
  logic [WIDTHB-1:0]     m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport slave (
    input  start, base_addr, length, doB, m_ready,
    output busy, done, reB, addrB, m_data, m_valid, m_last
  );

  modport master (
    output start, base_addr, length, doB, m_ready,
    input  busy, done, reB, addrB, m_data, m_valid, m_last
  );
endinterface

`default_nettype wire

// File: rtl/ram_stream_reader.sv
//------------------------------------------------------------------------------
// ram_stream_reader : streams a contiguous RAM region out with valid/ready
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ram_stream_reader #(
  parameter int WIDTHB     = 9,
  parameter int ADDRWIDTHB = 12,
  parameter int LENWIDTH   = 13
) (
  input  wire logic            clk,
  input  wire logic            rst,
  ram_stream_reader_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDRWIDTHB-1:0] r_addr;
  logic [LENWIDTH-1:0]   r_remaining;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic                  r_done;
  logic [WIDTHB-1:0]     r_buf_data [2];
  logic [1:0]            r_buf_last;
  logic [1:0]            r_cnt;

  logic                  w_re;
  logic                  w_accept;
  logic                  w_done_next;
  logic                  w_valid;
  logic                  w_last;
  logic [WIDTHB-1:0]     w_data;
  logic                  w_pop;
  logic                  w_pop_buf;
  logic                  w_push;
  logic                  w_credit;
  logic [1:0]            w_keep_cnt;

  // A word arriving from the RAM with an empty buffer is bypassed straight to
  // the stream, which gives the two-cycle first-word latency.
  always_comb begin
    w_valid = (r_cnt != 2'd0) || r_inflight;
    w_data  = '0;
    w_last  = 1'b0;
    if (r_cnt != 2'd0) begin
      w_data = r_buf_data[0];
      w_last = r_buf_last[0];
    end else if (r_inflight) begin
      w_data = bus.doB;
      w_last = r_inflight_last;
    end
    w_pop      = w_valid && bus.m_ready;
    w_pop_buf  = w_pop && (r_cnt != 2'd0);
    w_push     = r_inflight && !(w_pop && (r_cnt == 2'd0));
    w_keep_cnt = r_cnt - {1'b0, w_pop_buf};
    w_credit   = (({1'b0, r_inflight} + r_cnt) < 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_re         = 1'b0;
    w_accept     = 1'b0;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.length != '0) begin
            w_accept     = 1'b1;
            w_state_next = S_RUN;
          end else begin
            w_done_next = 1'b1;
          end
        end
      end
      S_RUN: begin
        w_re = w_credit;
        if (w_re && (r_remaining == LENWIDTH'(1))) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_pop && w_last) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr          <= '0;
      r_remaining     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done          <= 1'b0;
      r_cnt           <= 2'd0;
      r_buf_last      <= 2'b00;
      r_buf_data[0]   <= '0;
      r_buf_data[1]   <= '0;
    end else begin
      r_done          <= w_done_next;
      r_inflight      <= w_re;
      r_inflight_last <= w_re && (r_remaining == LENWIDTH'(1));
      if (w_accept) begin
        r_addr      <= bus.base_addr;
        r_remaining <= bus.length;
      end else if (w_re) begin
        r_addr      <= r_addr + ADDRWIDTHB'(1);
        r_remaining <= r_remaining - LENWIDTH'(1);
      end
      if (w_pop_buf) begin
        r_buf_data[0] <= r_buf_data[1];
        r_buf_last[0] <= r_buf_last[1];
      end
      // Push lands after the shift so it overrides slot 0 when the head leaves.
      if (w_push) begin
        r_buf_data[w_keep_cnt[0]] <= bus.doB;
        r_buf_last[w_keep_cnt[0]] <= r_inflight_last;
      end
      r_cnt <= w_keep_cnt + {1'b0, w_push};
    end
  end

  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = r_done;
  assign bus.reB     = w_re;
  assign bus.addrB   = r_addr;
  assign bus.m_data  = w_data;
  assign bus.m_valid = w_valid;
  assign bus.m_last  = w_last;

endmodule

`default_nettype wire

// File: tb/tb_ram_stream_reader.sv
//------------------------------------------------------------------------------
// tb_ram_stream_reader : directed + randomized bench with a RAM model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ram_stream_reader;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [8:0] ram [0:4095];

  ram_stream_reader_if #(.WIDTHB(9), .ADDRWIDTHB(12), .LENWIDTH(13)) bus ();

  ram_stream_reader #(.WIDTHB(9), .ADDRWIDTHB(12), .LENWIDTH(13)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Registered-read RAM: data appears the cycle after reB.
  always @(posedge clk) begin
    if (bus.reB) bus.doB <= ram[bus.addrB];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},    32'(bus.busy),    32'd0);
    check({tag, "_done"},    32'(bus.done),    32'd0);
    check({tag, "_reB"},     32'(bus.reB),     32'd0);
    check({tag, "_addrB"},   32'(bus.addrB),   32'd0);
    check({tag, "_m_valid"}, 32'(bus.m_valid), 32'd0);
    check({tag, "_m_last"},  32'(bus.m_last),  32'd0);
    check({tag, "_m_data"},  32'(bus.m_data),  32'd0);
  endtask

  // One full transfer checked against a queue of expected words.
  task automatic run_xfer(input int base, input int len, input bit rnd, input bit second_start);
    int   q_data[$];
    bit   q_last[$];
    int   issued = 0;
    int   accepted = 0;
    int   cyc = 0;
    bit   got_done = 1'b0;
    bit   pv_stall = 1'b0;
    logic [8:0] pd = '0;
    logic pl = 1'b0;
    int   exp_d;
    bit   exp_l;
    for (int i = 0; i < len; i++) begin
      q_data.push_back(int'(ram[(base + i) & 32'hFFF]));
      q_last.push_back(i == len - 1);
    end
    @(negedge clk);
    bus.start     = 1'b1;
    bus.base_addr = 12'(base);
    bus.length    = 13'(len);
    bus.m_ready   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (!got_done && cyc < 20000) begin
      if (second_start && cyc == 3) begin
        bus.start     = 1'b1;
        bus.base_addr = 12'h700;
        bus.length    = 13'd5;
      end else begin
        bus.start = 1'b0;
      end
      if (rnd) bus.m_ready = 1'($urandom_range(0, 1));
      if (pv_stall) begin
        check("stall_valid", 32'(bus.m_valid), 32'd1);
        check("stall_data",  32'(bus.m_data),  32'(pd));
        check("stall_last",  32'(bus.m_last),  32'(pl));
      end
      if (bus.reB) begin
        check("addrB", 32'(bus.addrB), (base + issued) & 32'hFFF);
        check("credit", 32'((issued - accepted) < 2), 32'd1);
        if (!rnd) check("reB_cycle", cyc, issued);
        issued++;
      end
      if (bus.m_valid && bus.m_ready) begin
        if (q_data.size() == 0) begin
          check("extra_word", 32'd1, 32'd0);
        end else begin
          exp_d = q_data.pop_front();
          exp_l = q_last.pop_front();
          check("m_data", 32'(bus.m_data), exp_d);
          check("m_last", 32'(bus.m_last), 32'(exp_l));
          if (!rnd) check("word_cycle", cyc, accepted + 1);
        end
        accepted++;
      end
      pv_stall = bus.m_valid && !bus.m_ready;
      pd = bus.m_data;
      pl = bus.m_last;
      if (bus.done) begin
        got_done = 1'b1;
        check("done_busy", 32'(bus.busy), 32'd0);
        check("done_words", accepted, len);
        check("done_reads", issued, len);
        if (len == 0) check("zero_done_cycle", cyc, 0);
        else if (!rnd) check("done_cycle", cyc, len + 1);
      end else begin
        check("busy", 32'(bus.busy), 32'(len != 0));
        @(negedge clk);
        cyc++;
      end
    end
    check("timeout", 32'(got_done), 32'd1);
    bus.start = 1'b0;
    @(negedge clk);
    check("done_pulse_end", 32'(bus.done), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_reB", 32'(bus.reB), 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.length    = '0;
    bus.m_ready   = 1'b0;
    for (int i = 0; i < 4096; i++) ram[i] = 9'(i);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    run_xfer(32'h010, 8, 1'b0, 1'b0);
    run_xfer(32'hFFE, 4, 1'b0, 1'b0);

    for (int i = 0; i < 4096; i++) ram[i] = 9'($urandom);
    run_xfer(int'($urandom_range(0, 4095)), 16, 1'b1, 1'b0);
    run_xfer(int'($urandom_range(0, 4095)), int'($urandom_range(1, 40)), 1'b1, 1'b0);

    run_xfer(32'h100, 0, 1'b0, 1'b0);
    run_xfer(32'h200, 8, 1'b1, 1'b1);

    // Reset three cycles into a transfer aborts it silently.
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = 12'h300; bus.length = 13'd8; bus.m_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_done", 32'(bus.done), 32'd0);
      check("post_rst_valid", 32'(bus.m_valid), 32'd0);
    end
    run_xfer(int'($urandom_range(0, 4095)), 2, 1'b0, 1'b0);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1; bus.base_addr = 12'h050; bus.length = 13'd4;
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    check("rst_prio_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("rst_prio_reB", 32'(bus.reB), 32'd0);

    run_xfer(32'h123, 4096, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 Parameter WIDTHB, default 9: width of a RAM read word and of a stream word.
REQ-002 Parameter ADDRWIDTHB, default 12: RAM read-port address width.
REQ-003 Parameter LENWIDTH, default 13: width of the transfer length; it SHALL be ADDRWIDTHB+1 so that a full-RAM length is expressible.
REQ-004 clk  in  1: single clock; all logic SHALL be clocked on the rising edge.
REQ-005 rst  in  1: synchronous, active-high reset.
REQ-006 start  in  1: one-cycle command strobe.
REQ-007 base_addr  in  ADDRWIDTHB: first RAM address of the transfer.
REQ-008 length  in  LENWIDTH: number of words to transfer, 0..2^ADDRWIDTHB.
REQ-009 busy  out  1: high while a transfer is in progress.
REQ-010 done  out  1: one-cycle pulse at the end of a transfer.
REQ-011 reB  out  1: RAM read enable.
REQ-012 addrB  out  ADDRWIDTHB: RAM read address.
REQ-013 doB  in  WIDTHB: registered RAM read data, valid exactly 1 cycle after the cycle in which reB=1.
REQ-014 m_data  out  WIDTHB: stream data.
REQ-015 m_valid  out  1: stream valid.
REQ-016 m_ready  in  1: stream ready.
REQ-017 m_last  out  1: marks the final word of a transfer.

Function
REQ-018 FSM states SHALL be IDLE, RUN and DRAIN.
REQ-019 IDLE -> RUN on start=1 with length!=0; the block SHALL latch base_addr and length, and busy SHALL rise in the next cycle.
REQ-020 On start=1 with length=0 in IDLE, the block SHALL issue no reads, SHALL keep busy low, and SHALL pulse done in the next cycle.
REQ-021 start while busy=1 SHALL be ignored.
REQ-022 In RUN, reB SHALL assert only when (reads in flight + words held in the output buffer) < 2.
- The output buffer SHALL be 2 entries.
- No word SHALL ever be dropped or duplicated under any m_ready pattern.
REQ-023 addrB SHALL start at base_addr and increment by 1 per issued read, modulo 2^ADDRWIDTHB.
- Example: base_addr=0xFFE, length=4 reads 0xFFE, 0xFFF, 0x000, 0x001.
REQ-024 RUN -> DRAIN once the length-th read has been issued; reB SHALL be 0 in DRAIN and IDLE.
REQ-025 Words SHALL appear on m_data in address order, with the same value the RAM returned.
REQ-026 A word SHALL transfer on a cycle with m_valid=1 and m_ready=1.
REQ-027 While m_valid=1 and m_ready=0, m_data, m_valid and m_last SHALL hold steady.
REQ-028 m_last SHALL equal 1 only together with the length-th word.
REQ-029 DRAIN -> IDLE in the cycle after the m_last handshake.
- done SHALL pulse for exactly that one cycle.
- busy SHALL fall in that same cycle.
REQ-030 With m_ready held at 1, throughput SHALL be 1 word/cycle after the initial latency.
- First reB SHALL occur in the cycle after start.
- First m_valid SHALL occur 2 cycles after start.
REQ-031 If a buffered word's handshake and a new doB arrival fall in the same cycle, both SHALL be handled in that cycle without stall or loss.
REQ-032 Internal word counters SHALL be LENWIDTH bits wide so that length=2^ADDRWIDTHB (4096) completes correctly.

Reset
REQ-033 On rst=1 the block SHALL go to IDLE and drive busy=0, done=0, reB=0, addrB=0, m_valid=0, m_last=0 and m_data=0.
REQ-034 On rst=1 the block SHALL flush the output buffer and clear the in-flight tracking.
REQ-035 rst asserted mid-transfer SHALL abort the transfer with no done pulse.
- Any doB returned after reset SHALL be discarded.
REQ-036 rst SHALL take priority over start in the same cycle.

Verification
REQ-037 RAM preloaded with RAM[i]=i[8:0], base_addr=0x010, length=8, m_ready=1 -> output 0x010..0x017, one word per cycle, m_last on 0x017, done 1 cycle after that handshake.
REQ-038 base_addr=0xFFE, length=4 -> addrB sequence 0xFFE, 0xFFF, 0x000, 0x001, and data in the same order.
REQ-039 length=16 with random m_ready (50%) -> 16 words in order, no loss or duplication, outputs stable while stalled, reB never issued with 2 words buffered or outstanding.
REQ-040 length=0 -> no reB, busy stays 0, done pulses once in the next cycle; a second start while busy=1 during a length=8 run -> ignored, exactly 8 words output.
REQ-041 rst asserted 3 cycles into a length=8 run -> all outputs at reset values in the next cycle, no done pulse; a new length=2 start afterwards -> correct 2 words.
REQ-042 length=4096, base_addr=0x123, m_ready=1 -> 4096 words covering every address once, m_last on address 0x122.
